// File: rtl/not_gate_stim_checker.sv
// not_gate_stim_checker
// Clocked stimulus-and-check stage wrapped around an inverter path. On each
// accepted start it walks vector k = k mod 2^WIDTH onto dut_in, waits
// SETTLE_CYCLES, samples dut_out and compares it with ~dut_in. Mismatches are
// counted (saturating), flagged with a one-cycle err_pulse, and the index of
// the first failing vector is kept. done/pass report the run result.
//
// Ports:
//   clk        rising-edge clock
//   reset_L    asynchronous active-low reset
//   start      single-cycle run request, honoured in IDLE or DONE only
//   dut_out    inverter output under test
//   dut_in     registered stimulus to inverter input
//   busy       run in progress
//   done       run finished, held until the next accepted start
//   pass       valid with done; 1 when no vector failed
//   err_count  saturating count of failing vectors
//   err_pulse  one-cycle pulse after a failing sample
//   first_fail index of the first failing vector, 0 if none
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_SETTLE | vector applied, counting down settle_cnt
// S_SAMPLE | compare dut_out with ~dut_in, advance or finish
// S_DONE   | results held, start begins a new run
module not_gate_stim_checker #(
   parameter int WIDTH         = 1,
   parameter int NUM_VECTORS   = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             start,
   input  logic [WIDTH-1:0] dut_out,
   output logic [WIDTH-1:0] dut_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             err_pulse,
   output logic [15:0]      first_fail
);

   localparam int              SC_W          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SC_W-1:0] SETTLE_RELOAD = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [15:0]     LAST_IDX      = 16'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [15:0]      vec_idx_q, vec_idx_d;
   logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [WIDTH-1:0] dut_in_q, dut_in_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [15:0]      first_fail_q, first_fail_d;
   logic             pass_q, pass_d;
   logic             err_pulse_q, err_pulse_d;

   logic accept;
   logic mismatch;
   logic last_vec;

   assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   // Case inequality so an X/Z on the path under test counts as a failure.
   assign mismatch = (dut_out !== ~dut_in_q);
   assign last_vec = (vec_idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q      <= S_IDLE;
         vec_idx_q    <= '0;
         settle_cnt_q <= '0;
         dut_in_q     <= '0;
         err_count_q  <= '0;
         first_fail_q <= '0;
         pass_q       <= 1'b0;
         err_pulse_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_idx_q    <= vec_idx_d;
         settle_cnt_q <= settle_cnt_d;
         dut_in_q     <= dut_in_d;
         err_count_q  <= err_count_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
         err_pulse_q  <= err_pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE,
         S_DONE:   if (start) state_d = S_SETTLE;
         S_SETTLE: if (settle_cnt_q == '0) state_d = S_SAMPLE;
         S_SAMPLE: state_d = last_vec ? S_DONE : S_SETTLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      vec_idx_d    = vec_idx_q;
      settle_cnt_d = settle_cnt_q;
      dut_in_d     = dut_in_q;
      err_count_d  = err_count_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;
      err_pulse_d  = 1'b0;

      if (accept) begin
         vec_idx_d    = '0;
         settle_cnt_d = SETTLE_RELOAD;
         dut_in_d     = '0;
         err_count_d  = '0;
         first_fail_d = '0;
         pass_d       = 1'b0;
      end else if (state_q == S_SETTLE) begin
         if (settle_cnt_q != '0) settle_cnt_d = settle_cnt_q - SC_W'(1);
      end else if (state_q == S_SAMPLE) begin
         if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
            // The counter saturates rather than wraps, so zero means no failure yet.
            if (err_count_q == '0) first_fail_d = vec_idx_q;
         end
         if (last_vec) begin
            pass_d = (err_count_d == '0);
         end else begin
            vec_idx_d    = vec_idx_q + 16'd1;
            dut_in_d     = WIDTH'(vec_idx_q + 16'd1);
            settle_cnt_d = SETTLE_RELOAD;
         end
      end
   end

   always_comb begin
      busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
      done       = (state_q == S_DONE);
      dut_in     = dut_in_q;
      pass       = pass_q;
      err_count  = err_count_q;
      err_pulse  = err_pulse_q;
      first_fail = first_fail_q;
   end

endmodule

// File: tb/tb_not_gate_stim_checker.sv
module tb_not_gate_stim_checker;

   localparam int W   = 2;
   localparam int NV  = 6;
   localparam int SC  = 2;
   localparam int EW  = 2;
   localparam int P   = SC + 1;
   localparam int MAXE = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  dut_in;
   logic [W-1:0]  dut_out;
   logic [W-1:0]  cur_mask = '0;
   logic          busy, done, pass, err_pulse;
   logic [EW-1:0] err_count;
   logic [15:0]   first_fail;

   int n_cmp = 0;
   int n_err = 0;
   int mask_a[NV];
   bit fail_a[NV];

   always #5 clk = ~clk;

   // Inverter model with a per-vector corruption mask; zero mask is a good inverter.
   assign dut_out = ~dut_in ^ cur_mask;

   not_gate_stim_checker #(
      .WIDTH(W), .NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .ERR_W(EW)
   ) u_dut (
      .clk(clk), .reset_L(reset_L), .start(start), .dut_out(dut_out),
      .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .err_pulse(err_pulse), .first_fail(first_fail)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int fails_upto(input int k);
      int n = 0;
      for (int i = 0; i < k; i++) if (fail_a[i]) n++;
      return (n > MAXE) ? MAXE : n;
   endfunction

   function automatic int first_upto(input int k);
      for (int i = 0; i < k; i++) if (fail_a[i]) return i;
      return 0;
   endfunction

   // mode 0: good inverter, 1: output stuck at 0, 2: buffer, 3: random corruption
   task automatic plan(input int mode);
      for (int k = 0; k < NV; k++) begin
         int vec = k % (1 << W);
         case (mode)
            0: mask_a[k] = 0;
            1: mask_a[k] = (~vec) & ((1 << W) - 1);
            2: mask_a[k] = (1 << W) - 1;
            default: mask_a[k] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, (1 << W) - 1);
         endcase
         fail_a[k] = (mask_a[k] != 0);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_dut_in"}, 32'(dut_in), 0);
      check_eq({tag, "_busy"}, 32'(busy), 0);
      check_eq({tag, "_done"}, 32'(done), 0);
      check_eq({tag, "_pass"}, 32'(pass), 0);
      check_eq({tag, "_err_count"}, 32'(err_count), 0);
      check_eq({tag, "_err_pulse"}, 32'(err_pulse), 0);
      check_eq({tag, "_first_fail"}, 32'(first_fail), 0);
   endtask

   // Issue a start and follow the whole run cycle by cycle against the plan.
   task automatic run(input int mode, input bit noisy_start);
      plan(mode);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 0; j <= NV * P; j++) begin
         int k, vi, pexp;
         if (j > 0) begin @(posedge clk); #1; end
         start = 1'b0;
         k  = j / P;
         vi = (k < NV) ? k : NV - 1;
         if (k < NV) cur_mask = W'(mask_a[k]);
         pexp = (j > 0 && (j % P) == 0) ? int'(fail_a[k - 1]) : 0;
         check_eq("dut_in", 32'(dut_in), 32'(vi % (1 << W)));
         check_eq("busy", 32'(busy), 32'(j < NV * P));
         check_eq("done", 32'(done), 32'(j == NV * P));
         check_eq("err_pulse", 32'(err_pulse), 32'(pexp));
         check_eq("err_count", 32'(err_count), 32'(fails_upto(k)));
         check_eq("first_fail", 32'(first_fail), 32'(first_upto(k)));
         check_eq("pass", 32'(pass), (j == NV * P) ? 32'(fails_upto(NV) == 0) : 32'd0);
         if (noisy_start && j < NV * P && $urandom_range(0, 3) == 0) start = 1'b1;
      end
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      #2 reset_L = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("idle");

      run(0, 1'b0);
      run(1, 1'b0);
      run(2, 1'b0);
      run(0, 1'b1);
      for (int r = 0; r < 12; r++) begin
         run(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
         #1;
      end

      // Abort mid-run by asserting reset between clock edges.
      plan(2);
      cur_mask = W'(mask_a[0]);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat ($urandom_range(4, 14)) @(posedge clk);
      #3 reset_L = 1'b0;
      #1 check_reset_vals("async_rst");
      repeat (2) @(posedge clk);
      #1 check_reset_vals("rst_hold");
      #2 reset_L = 1'b1;
      @(posedge clk); #1;
      run(0, 1'b0);
      run(3, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
